// File: rtl/pipe_stage_bank_pkg.sv
// Shared definitions for the pipeline stage register bank: bubble instruction,
// stage indices and the bank's reset/drain/run state encoding.
package pipeline_structs_defs;

  localparam int          N_STAGES   = 4;
  localparam logic [31:0] NOP_IR_DEF = 32'h0000_0013;

  // Last value of the drain counter; the bank spends DRAIN_LAST+1 cycles draining.
  localparam logic [1:0]  DRAIN_LAST = 2'd2;

  typedef enum logic [1:0] {
    IFDE  = 2'd0,
    DEEX  = 2'd1,
    EXMEM = 2'd2,
    MEMWB = 2'd3
  } stage_idx_t;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } pipe_bank_state_t;

endpackage

// File: rtl/pipe_stage_bank_stage_reg.sv
// One pipeline stage register: flush > enable > hold, with optional bubble and
// stall counters built only when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg
  import pipeline_structs_defs::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] NOP_IR = WIDTH'(NOP_IR_DEF),
  parameter int               CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_en,
  input  logic             i_run_state,
  input  logic [WIDTH-1:0] i_d_ir,
  input  logic [WIDTH-1:0] i_d_pc,
  input  logic             i_d_vld,
  output logic [WIDTH-1:0] o_q_ir,
  output logic [WIDTH-1:0] o_q_pc,
  output logic             o_q_vld,
  output logic [CNT_W-1:0] o_bubble_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_pc;
  logic             r_vld;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_ir  <= NOP_IR;
      r_pc  <= '0;
      r_vld <= 1'b0;
    end else if (i_en) begin
      r_ir  <= i_d_ir;
      r_pc  <= i_d_pc;
      r_vld <= i_d_vld;
    end
  end

  assign o_q_ir  = r_ir;
  assign o_q_pc  = r_pc;
  assign o_q_vld = r_vld;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  // Stalls are only meaningful once the bank is running; drain flushes are bubbles.
  assign w_stall = i_run_state & ~i_en & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (i_flush && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))  r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_bubble_cnt = r_bubble_cnt;
  assign o_stall_cnt  = r_stall_cnt;
`else
  logic w_unused_run;

  assign w_unused_run = i_run_state;
  assign o_bubble_cnt = '0;
  assign o_stall_cnt  = '0;
`endif

endmodule

// File: rtl/pipe_stage_bank.sv
// Four-stage pipeline register bank (IFDE, DEEX, EXMEM, MEMWB) with a post-reset
// drain sequencer. Optional perf counters: define PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_bank
  import pipeline_structs_defs::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] NOP_IR = WIDTH'(NOP_IR_DEF),
  parameter int               CNT_W  = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [3:0]            en,
  input  logic [3:0]            fl,
  input  logic [4*WIDTH-1:0]    d_ir,
  input  logic [4*WIDTH-1:0]    d_pc,
  input  logic [3:0]            d_vld,
  output logic [4*WIDTH-1:0]    q_ir,
  output logic [4*WIDTH-1:0]    q_pc,
  output logic [3:0]            q_vld,
  output logic                  run,
  output logic                  pipe_empty,
  output logic [4*CNT_W-1:0]    bubble_cnt,
  output logic [4*CNT_W-1:0]    stall_cnt,
  output logic [1:0]            o_dbg_state
);

  pipe_bank_state_t r_state;
  pipe_bank_state_t w_state_nxt;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       w_drain_cnt_nxt;
  logic             r_run;
  logic             w_drain;
  logic             w_run_state;
  logic [3:0]       w_flush;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= RESET;
      r_drain_cnt <= '0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_run       <= (w_state_nxt == RUN);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      RESET: begin
        w_state_nxt     = DRAIN;
        w_drain_cnt_nxt = '0;
      end
      DRAIN: begin
        if (r_drain_cnt == DRAIN_LAST) begin
          w_state_nxt     = RUN;
          w_drain_cnt_nxt = '0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + 2'd1;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt     = RESET;
        w_drain_cnt_nxt = '0;
      end
    endcase
  end

  assign w_drain     = (r_state == DRAIN);
  assign w_run_state = (r_state == RUN);

  // The fetch stage keeps accepting during drain; downstream stages are forced to bubbles.
  assign w_flush[int'(IFDE)]  = fl[int'(IFDE)];
  assign w_flush[int'(DEEX)]  = fl[int'(DEEX)]  | w_drain;
  assign w_flush[int'(EXMEM)] = fl[int'(EXMEM)] | w_drain;
  assign w_flush[int'(MEMWB)] = fl[int'(MEMWB)] | w_drain;

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    pipe_stage_reg #(
      .WIDTH  (WIDTH),
      .NOP_IR (NOP_IR),
      .CNT_W  (CNT_W)
    ) u_stage (
      .i_clk        (CLK),
      .i_rst_n      (RST_N),
      .i_flush      (w_flush[k]),
      .i_en         (en[k]),
      .i_run_state  (w_run_state),
      .i_d_ir       (d_ir[k*WIDTH +: WIDTH]),
      .i_d_pc       (d_pc[k*WIDTH +: WIDTH]),
      .i_d_vld      (d_vld[k]),
      .o_q_ir       (q_ir[k*WIDTH +: WIDTH]),
      .o_q_pc       (q_pc[k*WIDTH +: WIDTH]),
      .o_q_vld      (q_vld[k]),
      .o_bubble_cnt (bubble_cnt[k*CNT_W +: CNT_W]),
      .o_stall_cnt  (stall_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign run         = r_run;
  assign pipe_empty  = ~|q_vld;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed bench for pipe_stage_bank: reset, drain timing, load/stall/flush,
// mid-run reset and counter saturation (expectations follow PIPE_STAGE_PERF_CNT_EN).
module tb_pipe_stage_bank;
  import pipeline_structs_defs::*;

  localparam int W  = 32;
  localparam int CW = 4;
`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            CLK;
  logic            RST_N;
  logic [3:0]      en;
  logic [3:0]      fl;
  logic [4*W-1:0]  d_ir;
  logic [4*W-1:0]  d_pc;
  logic [3:0]      d_vld;
  logic [4*W-1:0]  q_ir;
  logic [4*W-1:0]  q_pc;
  logic [3:0]      q_vld;
  logic            run;
  logic            pipe_empty;
  logic [4*CW-1:0] bubble_cnt;
  logic [4*CW-1:0] stall_cnt;
  logic [1:0]      o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_bank #(.WIDTH(W), .NOP_IR(32'h0000_0013), .CNT_W(CW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en          (en),
    .fl          (fl),
    .d_ir        (d_ir),
    .d_pc        (d_pc),
    .d_vld       (d_vld),
    .q_ir        (q_ir),
    .q_pc        (q_pc),
    .q_vld       (q_vld),
    .run         (run),
    .pipe_empty  (pipe_empty),
    .bubble_cnt  (bubble_cnt),
    .stall_cnt   (stall_cnt),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ir_of(input int k);
    return q_ir[k*W +: W];
  endfunction

  function automatic logic [W-1:0] pc_of(input int k);
    return q_pc[k*W +: W];
  endfunction

  function automatic logic [CW-1:0] bub_of(input int k);
    return bubble_cnt[k*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] stl_of(input int k);
    return stall_cnt[k*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] perf(input int v);
    return PERF ? CW'(v) : '0;
  endfunction

  // driver tasks
  task automatic set_stage(input int k, input logic [W-1:0] ir, input logic [W-1:0] pc);
    d_ir[k*W +: W] = ir;
    d_pc[k*W +: W] = pc;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_vld"}, q_vld, 4'h0);
    check_eq({tag, "_run"}, run, 1'b0);
    check_eq({tag, "_empty"}, pipe_empty, 1'b1);
    check_eq({tag, "_state"}, o_dbg_state, RESET);
    check_eq({tag, "_bub"}, bubble_cnt, '0);
    check_eq({tag, "_stl"}, stall_cnt, '0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_ir%0d", tag, k), ir_of(k), 32'h0000_0013);
      check_eq($sformatf("%s_pc%0d", tag, k), pc_of(k), '0);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    en    = 4'h0;
    fl    = 4'h0;
    d_vld = 4'hF;
    for (int k = 0; k < 4; k++) set_stage(k, 32'($urandom_range(0, 32'hFFFF)), 32'($urandom_range(0, 32'hFFFF)));

    // reset held two cycles, garbage inputs must not leak through
    en = 4'hF;
    tick();
    tick();
    check_reset_state("rst");

    // release: drain three cycles, stage 0 keeps loading
    for (int k = 0; k < 4; k++) set_stage(k, 32'h100 + 32'(k), 32'h1000 + 32'(4 * k));
    RST_N = 1'b1;
    tick();
    check_eq("rel_state", o_dbg_state, DRAIN);
    check_eq("rel_run", run, 1'b0);
    for (int e = 2; e <= 4; e++) begin
      tick();
      check_eq($sformatf("drain_vld_e%0d", e), q_vld, 4'h1);
      check_eq($sformatf("drain_run_e%0d", e), run, (e == 4) ? 1'b1 : 1'b0);
    end
    check_eq("drain_ir3", ir_of(3), 32'h0000_0013);
    tick();
    check_eq("run_vld", q_vld, 4'hF);
    check_eq("run_ir2", ir_of(2), 32'h102);
    check_eq("run_pc2", pc_of(2), 32'h1008);
    check_eq("run_empty", pipe_empty, 1'b0);
    check_eq("drain_bub1", bub_of(1), perf(3));
    check_eq("drain_bub0", bub_of(0), perf(0));

    // load then stall stage 2 for five cycles; stage 3 keeps flowing
    set_stage(2, 32'hDEAD_BEEF, 32'h2000);
    tick();
    check_eq("ld_ir2", ir_of(2), 32'hDEAD_BEEF);
    en = 4'b1011;
    set_stage(2, 32'h1111_1111, 32'h3000);
    for (int c = 0; c < 5; c++) begin
      set_stage(3, 32'hCAFE_0000 + 32'(c), 32'h4000 + 32'(c));
      tick();
      check_eq($sformatf("stall_ir2_c%0d", c), ir_of(2), 32'hDEAD_BEEF);
      check_eq($sformatf("flow_ir3_c%0d", c), ir_of(3), 32'hCAFE_0000 + 32'(c));
    end
    check_eq("stall_pc2", pc_of(2), 32'h2000);
    check_eq("stall_cnt2", stl_of(2), perf(5));
    check_eq("stall_cnt1", stl_of(1), perf(0));

    // flush wins over enable on stage 1
    en = 4'hF;
    fl = 4'b0010;
    set_stage(1, 32'h1234_5678, 32'h5000);
    tick();
    fl = 4'h0;
    check_eq("fl_ir1", ir_of(1), 32'h0000_0013);
    check_eq("fl_vld1", q_vld[1], 1'b0);
    check_eq("fl_pc1", pc_of(1), '0);
    check_eq("fl_bub1", bub_of(1), perf(4));
    check_eq("fl_ir2", ir_of(2), 32'h1111_1111);

    // pipe_empty tracks valids
    d_vld = 4'h0;
    tick();
    check_eq("empty_all", pipe_empty, 1'b1);
    d_vld = 4'hF;
    tick();
    check_eq("full_vld", q_vld, 4'hF);

    // mid-run reset aborts everything in one edge, drain restarts on release
    RST_N = 1'b0;
    tick();
    check_reset_state("mid_rst");
    RST_N = 1'b1;
    tick();
    check_eq("re_state", o_dbg_state, DRAIN);
    tick();
    check_eq("re_drain_vld", q_vld, 4'h1);
    tick();
    tick();
    check_eq("re_run", run, 1'b1);
    check_eq("re_bub3", bub_of(3), perf(3));

    // saturation of a 4-bit bubble counter under continuous flush
    fl = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 10) check_eq("sat_bub3_13", bub_of(3), perf(13));
      if (c == 12) check_eq("sat_bub3_15", bub_of(3), perf(15));
    end
    check_eq("sat_bub3_hold", bub_of(3), perf(15));
    check_eq("sat_vld3", q_vld[3], 1'b0);
    fl = 4'h0;
    tick();
    check_eq("sat_reload_vld", q_vld, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
